// File: rtl/sici_pcs_rx_slip.sv
// ---------------------------------------------------------------------------
// sici_pcs_rx_slip
//   Receive-side bit-slip aligner for the PCS. It takes unaligned parallel
//   words from the deserializer and produces words shifted by a programmable
//   bit offset k. Each bit-slip request from the frame-sync block advances the
//   stream position by exactly one bit. A holdoff counter rate-limits
//   accepted slips.
//
// Parameters
//   FW      frame width in bits (data + 2-bit sync header), 8..64
//   HOLD    minimum CE-qualified cycles between accepted slips, 1..255
//
// Ports
//   Ck       in   clock, rising edge
//   Rs       in   synchronous active-high reset
//   CE       in   clock enable; all state advances only when high
//   Ser_Dat  in   unaligned word, MSB = first received bit
//   Bit_Slp  in   bit-slip request, sampled only when CE is high
//   Phy_Dat  out  aligned word, MSB = first bit in stream order
//   Dat_Vld  out  Phy_Dat holds a new, non-duplicated word
//   Slp_Ofs  out  current bit offset k (0..FW-1)
//   Slp_Ign  out  one-cycle pulse when a slip request is dropped in holdoff
// ---------------------------------------------------------------------------
module sici_pcs_rx_slip #(
    parameter int unsigned FW   = 40,
    parameter int unsigned HOLD = 8
) (
    input  logic                    Ck,
    input  logic                    Rs,
    input  logic                    CE,
    input  logic [FW-1:0]           Ser_Dat,
    input  logic                    Bit_Slp,
    output logic [FW-1:0]           Phy_Dat,
    output logic                    Dat_Vld,
    output logic [$clog2(FW)-1:0]   Slp_Ofs,
    output logic                    Slp_Ign
);

    localparam int unsigned     KW   = $clog2(FW);
    localparam logic [KW-1:0]   KMAX = KW'(FW - 1);

    // FILL : first CE edge after reset outputs the cleared D1, not stream data
    // RUN  : normal operation
    // WRAP : k just wrapped FW-1 -> 0; the next word repeats FW-1 bits of the
    //        previous one and is flagged invalid
    typedef enum logic [1:0] {
        ST_FILL,
        ST_RUN,
        ST_WRAP
    } state_t;

    state_t             r_state;
    logic [FW-1:0]      r_d1;
    logic [FW-1:0]      r_phy;
    logic [KW-1:0]      r_k;
    logic [7:0]         r_hold;
    logic               r_vld;
    logic               r_ign;

    logic [2*FW-1:0]    w_cat;
    logic [FW-1:0]      w_phy;
    logic               w_slip_ok;

    // Window into the two-word history; offset k selects the start bit
    // counted from the MSB of the older word.
    assign w_cat     = {r_d1, Ser_Dat};
    assign w_phy     = w_cat[(2*FW - 1 - r_k) -: FW];
    assign w_slip_ok = Bit_Slp && (r_hold == '0);

    always_ff @(posedge Ck) begin
        if (Rs) begin
            r_state <= ST_FILL;
            r_d1    <= '0;
            r_phy   <= '0;
            r_k     <= '0;
            r_hold  <= '0;
            r_vld   <= 1'b0;
            r_ign   <= 1'b0;
        end else begin
            r_vld <= 1'b0;
            r_ign <= 1'b0;
            if (CE) begin
                r_d1    <= Ser_Dat;
                r_phy   <= w_phy;
                r_vld   <= (r_state == ST_RUN);
                r_state <= ST_RUN;
                if (w_slip_ok) begin
                    r_hold <= 8'(HOLD);
                    if (r_k == KMAX) begin
                        r_k     <= '0;
                        r_state <= ST_WRAP;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end else begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - 1'b1;
                    end
                    // Reaching here with a request means holdoff is active
                    r_ign <= Bit_Slp;
                end
            end
        end
    end

    assign Phy_Dat = r_phy;
    assign Dat_Vld = r_vld;
    assign Slp_Ofs = r_k;
    assign Slp_Ign = r_ign;

endmodule

// File: tb/tb_sici_pcs_rx_slip.sv
// ---------------------------------------------------------------------------
// tb_sici_pcs_rx_slip
//   Directed and randomized stimulus for sici_pcs_rx_slip. The reference model
//   treats the input as one continuous bit stream (word e occupies stream bits
//   e*FW .. e*FW+FW-1, MSB first); an output word at CE edge e starts at
//   stream position (e-1)*FW + k. A word is valid only if it does not overlap
//   the previous valid word. Slips are accepted when no slip was accepted in
//   the previous HOLD CE cycles.
// ---------------------------------------------------------------------------
module tb_sici_pcs_rx_slip;

    localparam int FW   = 40;
    localparam int HOLD = 8;
    localparam int KW   = $clog2(FW);

    logic           Ck      = 1'b0;
    logic           Rs      = 1'b1;
    logic           CE      = 1'b0;
    logic [FW-1:0]  Ser_Dat = '0;
    logic           Bit_Slp = 1'b0;
    logic [FW-1:0]  Phy_Dat;
    logic           Dat_Vld;
    logic [KW-1:0]  Slp_Ofs;
    logic           Slp_Ign;

    sici_pcs_rx_slip #(
        .FW   (FW),
        .HOLD (HOLD)
    ) dut (
        .Ck      (Ck),
        .Rs      (Rs),
        .CE      (CE),
        .Ser_Dat (Ser_Dat),
        .Bit_Slp (Bit_Slp),
        .Phy_Dat (Phy_Dat),
        .Dat_Vld (Dat_Vld),
        .Slp_Ofs (Slp_Ofs),
        .Slp_Ign (Slp_Ign)
    );

    always #5 Ck = ~Ck;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [FW-1:0]  words[$];
    int             k_m;
    bit             has_acc;
    int             last_acc;
    bit             has_prev;
    int             prev_start;
    logic [FW-1:0]  exp_phy;
    logic           exp_vld;
    logic           exp_ign;

    bit             inc_mode = 1'b0;
    logic [FW-1:0]  inc_val  = '0;

    // observation counters for scenario-level checks
    int obs_ign;
    int obs_inv;

    function automatic logic stream_bit(input int pos);
        logic [FW-1:0] w;
        w = words[pos / FW];
        return w[FW - 1 - (pos % FW)];
    endfunction

    task automatic model_reset();
        words.delete();
        k_m      = 0;
        has_acc  = 1'b0;
        last_acc = 0;
        has_prev = 1'b0;
        prev_start = 0;
        exp_phy  = '0;
        exp_vld  = 1'b0;
        exp_ign  = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic rs, input logic ce, input logic slp);
        logic [FW-1:0] w;
        int e;
        int start;
        if (inc_mode) begin
            w = inc_val;
            inc_val = inc_val + 1'b1;
        end else begin
            w = FW'({$urandom(), $urandom()});
        end
        Rs      = rs;
        CE      = ce;
        Bit_Slp = slp;
        Ser_Dat = w;
        @(posedge Ck);
        #1;
        exp_ign = 1'b0;
        if (rs) begin
            model_reset();
        end else if (ce) begin
            words.push_back(w);
            e = words.size() - 1;
            if (e == 0) begin
                exp_phy = '0;
                exp_vld = 1'b0;
            end else begin
                start = (e - 1) * FW + k_m;
                for (int i = 0; i < FW; i++) exp_phy[FW-1-i] = stream_bit(start + i);
                exp_vld = !has_prev || (start >= prev_start + FW);
                if (exp_vld) begin
                    has_prev   = 1'b1;
                    prev_start = start;
                end
            end
            if (slp) begin
                if (!has_acc || (e - last_acc > HOLD)) begin
                    k_m      = (k_m + 1) % FW;
                    has_acc  = 1'b1;
                    last_acc = e;
                end else begin
                    exp_ign = 1'b1;
                end
            end
        end else begin
            exp_vld = 1'b0;
        end
        check("phy", Phy_Dat, exp_phy);
        check("vld", Dat_Vld, exp_vld);
        check("ofs", Slp_Ofs, k_m);
        check("ign", Slp_Ign, exp_ign);
        if (Slp_Ign === 1'b1) obs_ign++;
        if (!rs && ce && Dat_Vld !== 1'b1) obs_inv++;
    endtask

    initial begin
        model_reset();

        // reset with a slip request on the same edge: reset wins
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);

        // incrementing stream, no slip: 2-edge latency, continuous valid
        inc_mode = 1'b1;
        inc_val  = FW'(1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0);
        check("s1_ofs", Slp_Ofs, 0);

        // single slip at k=0
        step(1'b0, 1'b1, 1'b1);
        check("s2_ofs", Slp_Ofs, 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        inc_mode = 1'b0;

        // slip held for 20 CE cycles
        step(1'b1, 1'b1, 1'b0);
        obs_ign = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
        check("s3_ign_cnt", obs_ign, 17);
        check("s3_ofs", Slp_Ofs, 3);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);

        // 40 spaced slips: full wrap with exactly one invalid word
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        obs_inv = 0;
        for (int s = 0; s < 40; s++) begin
            step(1'b0, 1'b1, 1'b1);
            for (int i = 0; i < HOLD + 1; i++) step(1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0);
        check("s4_inv_cnt", obs_inv, 1);
        check("s4_ofs", Slp_Ofs, 0);

        // CE toggling with slips only on CE=0 cycles
        obs_ign = 0;
        for (int i = 0; i < 20; i++) step(1'b0, (i % 2) == 0, (i % 2) == 1);
        check("s5_ign_cnt", obs_ign, 0);
        check("s5_ofs", Slp_Ofs, 0);

        // reset during holdoff at k=17, then immediate slip
        step(1'b1, 1'b1, 1'b0);
        for (int s = 0; s < 16; s++) begin
            step(1'b0, 1'b1, 1'b1);
            for (int i = 0; i < HOLD + 1; i++) step(1'b0, 1'b1, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1);
        check("s6_ofs_pre", Slp_Ofs, 17);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("s6_ofs_rst", Slp_Ofs, 0);
        check("s6_vld_rst", Dat_Vld, 0);
        step(1'b0, 1'b1, 1'b1);
        check("s6_ofs_post", Slp_Ofs, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) == 0, $urandom_range(3) != 0, $urandom_range(4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sici_pcs_rx_slip.md
SICI_PCS_RX_SLIP -- requirements
Module: sici_pcs_rx_slip

Interface
REQ-001 The block SHALL have parameter FW, default 40: PCS frame width in bits (data plus 2-bit SH); legal range 8..64.
REQ-002 The block SHALL have parameter HOLD, default 8: minimum number of CE-qualified cycles between two accepted slips; legal range 1..255.
REQ-003 The block SHALL have port Ck, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port Rs, input, 1 bit: reset, synchronous to Ck, active-high.
REQ-005 The block SHALL have port CE, input, 1 bit: clock enable, active-high; all state advances only when CE=1.
REQ-006 The block SHALL have port Ser_Dat, input, FW bits: unaligned parallel word from the deserializer; the MSB is the first-received bit.
REQ-007 The block SHALL have port Bit_Slp, input, 1 bit: bit-slip request from the frame-sync block, active-high, sampled only when CE=1.
REQ-008 The block SHALL have port Phy_Dat, output, FW bits: aligned word to the frame-sync block; the MSB is the first bit in stream order.
REQ-009 The block SHALL have port Dat_Vld, output, 1 bit: Phy_Dat holds a new, non-duplicated word.
REQ-010 The block SHALL have port Slp_Ofs, output, $clog2(FW) bits: current bit offset k, 0..FW-1.
REQ-011 The block SHALL have port Slp_Ign, output, 1 bit: one-cycle pulse when a Bit_Slp request is discarded during holdoff.

Function
REQ-012 On each CE cycle, the block SHALL capture Ser_Dat into register D1.
REQ-013 On each CE cycle, the block SHALL register Phy_Dat <= W[2FW-1-k -: FW], where W = {D1, Ser_Dat} (2FW bits, D1 in the upper half).
REQ-014 With k=0, the latency from Ser_Dat to Phy_Dat SHALL be exactly 2 CE-qualified edges.
REQ-015 A Bit_Slp sampled with CE=1, holdoff counter=0, and k<FW-1 SHALL set k<=k+1; the new k SHALL take effect on the Phy_Dat produced at the next CE edge.
REQ-016 Wrap boundary: an accepted slip with k=FW-1 SHALL set k<=0, and the next Phy_Dat word SHALL be flagged Dat_Vld=0, because it overlaps the previous word; output resumes Dat_Vld=1 on the following CE cycle.
REQ-017 Every accepted slip SHALL load the holdoff counter with HOLD; the counter SHALL decrement by 1 on each CE cycle while it is nonzero.
REQ-018 A Bit_Slp with CE=1 and holdoff counter nonzero SHALL leave k unchanged and pulse Slp_Ign for one Ck cycle.
REQ-019 A Bit_Slp held high continuously SHALL be accepted once every HOLD+1 CE cycles.
REQ-020 A Bit_Slp with CE=0 SHALL be ignored: no slip and no Slp_Ign.
REQ-021 When CE=0, D1, Phy_Dat, k and the holdoff counter SHALL hold their values; Dat_Vld and Slp_Ign SHALL be 0.
REQ-022 Outside reset and wrap, Dat_Vld SHALL equal the CE value registered on the previous Ck cycle (one-cycle pulse per CE-qualified output).
REQ-023 Slp_Ofs SHALL equal the registered k.
REQ-024 Data bits SHALL never be reordered; a slip SHALL only advance the stream position by exactly 1 bit.

Reset
REQ-025 Rs=1 at a Ck edge SHALL force the following, regardless of CE: D1=0, Phy_Dat=0, k=0, holdoff=0, Dat_Vld=0, Slp_Ign=0.
REQ-026 After reset deassertion, the first Dat_Vld=1 SHALL occur on the second CE-qualified edge.
REQ-027 Rs asserted mid-holdoff or mid-wrap SHALL abort that operation with no residual suppression.
REQ-028 Rs SHALL have priority over Bit_Slp sampled on the same edge.

Verification
REQ-029 The bench SHALL cover: FW=40, CE=1, Ser_Dat=incrementing stream, no slip -> Phy_Dat equals Ser_Dat delayed 2 cycles, Dat_Vld=1 continuously, Slp_Ofs=0.
REQ-030 The bench SHALL cover: a single Bit_Slp pulse at k=0 -> Slp_Ofs=1 next cycle, and the following Phy_Dat equals the stream advanced by 1 bit versus the reference model.
REQ-031 The bench SHALL cover: Bit_Slp held high for 20 CE cycles with HOLD=8 -> exactly 3 accepted slips (cycles 0, 9, 18), Slp_Ign pulsed 17 times, Slp_Ofs=3.
REQ-032 The bench SHALL cover: 40 spaced slips from k=0 -> Slp_Ofs goes 39 -> 0, exactly one Dat_Vld=0 word after the wrap, and the valid-word stream is continuous with 40 bits skipped in total.
REQ-033 The bench SHALL cover: CE toggling 1/0 with Bit_Slp asserted only on CE=0 cycles -> no slip, no Slp_Ign, and output advances only on CE=1 cycles.
REQ-034 The bench SHALL cover: Rs pulsed during holdoff at k=17 -> Slp_Ofs=0, Dat_Vld=0, and a Bit_Slp on the first cycle after reset is accepted (Slp_Ofs=1).
